apb_xfer_ctrl: RTL
==================

// Module: apb_xfer_ctrl
// PURPOSE
//  APB3 transfer sequencer between the command decoder and the APB slaves; single clock (apb_clk) domain.
//  Takes one decoded RAH command packet at a time over valid/ready, runs the SETUP/ACCESS handshake,
//  selects one of NUM_SLAVES PSELs, and pushes one response packet per transfer into pp_rd_fifo.
//  One transfer is outstanding at a time. It is the only owner of the APB bus.
// PARAMETERS
//  RAH_PACKET_WIDTH  48    command/response packet width; must be 48 (field map below)
//  NUM_SLAVES        4     PSEL fan-out, 1..8
//  TIMEOUT_CYCLES    256   ACCESS-phase cycle limit (only with APB_TIMEOUT_EN)
// PORTS
//  apb_clk            in   1    APB clock, all logic on the rising edge
//  apb_rst_n          in   1    asynchronous active-low reset
//  cmd_valid          in   1    decoder has a command
//  cmd_data           in   48   [47]=write [46:44]=slave idx [43:32]=PADDR [31:0]=PWDATA
//  cmd_ready          out  1    command accepted on cmd_valid & cmd_ready
//  psel               out  NUM_SLAVES  one-hot slave select
//  penable            out  1    APB access phase
//  pwrite             out  1    APB direction
//  paddr              out  12   APB address
//  pwdata             out  32   APB write data
//  prdata             in   32   slave read data (pre-muxed)
//  pready             in   1    slave ready
//  pslverr            in   1    slave error
//  pp_rd_fifo_full    in   1    response FIFO full
//  pp_rd_fifo_en      out  1    response push strobe
//  pp_rd_fifo_data    out  48   [47]=write [46]=slverr [45]=timeout [44:42]=slave idx [41:32]=paddr[11:2] [31:0]=rdata (0 for writes)
//  busy               out  1    FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, cmd_ready=0, pp_rd_fifo_en=0, busy=0.
//  Reset asserted mid-transfer aborts it at once: no response, and the command is lost.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs are registered.
//  IDLE: cmd_ready=1. On a handshake, latch the command and go to SETUP.
//  SETUP (1 cycle): psel[idx]=1, penable=0, address/data/direction stable. Go to ACCESS.
//  ACCESS: penable=1. Wait here while pready=0. On pready=1, capture prdata (reads only) and pslverr,
//    drop psel/penable next cycle, go to RESP.
//  RESP: when !pp_rd_fifo_full, pulse pp_rd_fifo_en for 1 cycle with the response and go to IDLE.
//    Otherwise hold the response and wait. The bus stays idle while waiting.
//  Slave idx >= NUM_SLAVES: skip SETUP/ACCESS, no PSEL, go straight to RESP with slverr=1, rdata=0.
//  Minimum latency from accept to push is 3 cycles (pready=1 in the first ACCESS cycle, FIFO not full).
//    Back-to-back throughput is 1 transfer per 4 cycles.
//  cmd_ready is 0 in every state except IDLE. A new command is never accepted in the cycle of a push.
//  pslverr is sampled only when pready=1. pwdata and paddr keep their last value when idle.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//    A counter runs in ACCESS. It clears on entry to ACCESS.
//    When it reaches TIMEOUT_CYCLES-1 with pready=0: drop psel/penable, set timeout=1 and slverr=0, rdata=0,
//    and go to RESP. A late pready is ignored.
//  APB_TIMEOUT_EN undefined: no counter. ACCESS waits forever and response bit [45] is tied to 0.
// STRUCTURE
//  Package apb_pkg: RAH_PACKET_WIDTH, command/response field bit positions, FSM state encoding
//    (localparam ST_IDLE/ST_SETUP/ST_ACCESS/ST_RESP), response bit build function.
//  Sub-module apb_timeout_cnt: clear/enable/expire counter, instantiated only under APB_TIMEOUT_EN.
//  Everything else is flat in this module.
// TESTING
//  Write idx1 addr 0x010 data 0xDEADBEEF, pready=1 at once -> psel=4'b0010 for 2 cycles, penable in cycle 2,
//    push 0x8_0_1_004_00000000 layout (write=1, slverr=0, rdata=0) 3 cycles after accept.
//  Read idx0 addr 0x020, pready low 3 cycles then high with prdata=0x12345678
//    -> ACCESS lasts 4 cycles, response rdata=0x12345678, slverr=0.
//  Read with pslverr=1 at pready -> response bit46=1. No retry. Next command accepted after the push.
//  pp_rd_fifo_full held 5 cycles after ACCESS ends -> no push, cmd_ready=0, psel=0.
//    Push occurs in the first cycle after full drops.
//  Idx 5 with NUM_SLAVES=4 -> psel stays 0, response slverr=1 two cycles after accept.
//  APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> bus released after 16 ACCESS cycles, response bit45=1.
//    Assert apb_rst_n low mid-ACCESS on a second run -> all outputs 0 on the same edge and no push.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB transfer sequencer: packet field map, FSM encoding
// and the response packet builder.
package apb_pkg;

  localparam int RAH_PACKET_WIDTH = 48;

  localparam int CMD_WRITE_BIT = 47;
  localparam int CMD_IDX_MSB   = 46;
  localparam int CMD_IDX_LSB   = 44;
  localparam int CMD_ADDR_MSB  = 43;
  localparam int CMD_ADDR_LSB  = 32;
  localparam int CMD_DATA_MSB  = 31;
  localparam int CMD_DATA_LSB  = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Response: write, slverr, timeout, slave idx, word address, read data.
  function automatic logic [RAH_PACKET_WIDTH-1:0] build_resp(
    input logic        write,
    input logic        slverr,
    input logic        timeout,
    input logic [2:0]  idx,
    input logic [11:0] addr,
    input logic [31:0] rdata
  );
    build_resp = {write, slverr, timeout, idx, addr[11:2], rdata};
  endfunction

endpackage

// File: rtl/apb_xfer_ctrl_if.sv
// Command, APB and response-FIFO signals of the transfer sequencer.
// master = the sequencer side, slave = the environment around it.
interface apb_xfer_ctrl_if #(
  parameter int NUM_SLAVES = 4
);
  logic                                  cmd_valid;
  logic [apb_pkg::RAH_PACKET_WIDTH-1:0]  cmd_data;
  logic                                  cmd_ready;
  logic [NUM_SLAVES-1:0]                 psel;
  logic                                  penable;
  logic                                  pwrite;
  logic [11:0]                           paddr;
  logic [31:0]                           pwdata;
  logic [31:0]                           prdata;
  logic                                  pready;
  logic                                  pslverr;
  logic                                  pp_rd_fifo_full;
  logic                                  pp_rd_fifo_en;
  logic [apb_pkg::RAH_PACKET_WIDTH-1:0]  pp_rd_fifo_data;
  logic                                  busy;

  modport master (
    input  cmd_valid, cmd_data, prdata, pready, pslverr, pp_rd_fifo_full,
    output cmd_ready, psel, penable, pwrite, paddr, pwdata, pp_rd_fifo_en, pp_rd_fifo_data, busy
  );

  modport slave (
    output cmd_valid, cmd_data, prdata, pready, pslverr, pp_rd_fifo_full,
    input  cmd_ready, psel, penable, pwrite, paddr, pwdata, pp_rd_fifo_en, pp_rd_fifo_data, busy
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase cycle counter: cleared outside ACCESS, flags the last allowed cycle.
module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic apb_clk,
  input  logic apb_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int          W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Count ACCESS cycles, holding at the limit.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);
endmodule

// File: rtl/apb_xfer_ctrl.sv
// APB3 transfer sequencer: one command in, one SETUP/ACCESS transfer, one response pushed.
// Define APB_TIMEOUT_EN to build the ACCESS-phase timeout.
module apb_xfer_ctrl
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            apb_clk,
  input  logic            apb_rst_n,
  apb_xfer_ctrl_if.master bus
);
  logic [1:0]                  r_state, w_next;
  logic [RAH_PACKET_WIDTH-1:0] r_cmd, w_cmd, r_resp, w_resp;
  logic [NUM_SLAVES-1:0]       r_psel, w_psel, w_onehot;
  logic [11:0]                 r_paddr, w_addr;
  logic [31:0]                 r_pwdata;
  logic [2:0]                  w_idx;
  logic r_cmd_ready, r_penable, r_pwrite, r_fifo_en, r_busy;
  logic w_accept, w_idx_ok, w_done, w_expire, w_fifo_en, w_wr;

  assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid && r_cmd_ready;
  assign w_cmd    = w_accept ? bus.cmd_data : r_cmd;
  assign w_wr     = w_cmd[CMD_WRITE_BIT];
  assign w_idx    = w_cmd[CMD_IDX_MSB:CMD_IDX_LSB];
  assign w_addr   = w_cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign w_idx_ok = ({1'b0, w_idx} < 4'(NUM_SLAVES));
  assign w_onehot = NUM_SLAVES'(1'b1) << w_idx;
  assign w_done   = (r_state == ST_ACCESS) && (bus.pready || w_expire);

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
    .apb_clk  (apb_clk),
    .apb_rst_n(apb_rst_n),
    .i_clr    (r_state != ST_ACCESS),
    .i_en     (r_state == ST_ACCESS),
    .o_expire (w_expire)
  );
`else
  // Without the timeout option ACCESS only ends on pready.
  assign w_expire = (TIMEOUT_CYCLES < 1);
`endif

  // State register.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; an out-of-range slave skips the bus phases entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_idx_ok ? ST_SETUP : ST_RESP; else w_next = ST_IDLE;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_done) w_next = ST_RESP; else w_next = ST_ACCESS;
      ST_RESP:   if (r_fifo_en) w_next = ST_IDLE; else w_next = ST_RESP;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode: next-cycle values of the registered outputs.
  always_comb begin
    w_psel    = '0;
    w_fifo_en = 1'b0;
    w_resp    = r_resp;
    if ((w_next == ST_SETUP) || (w_next == ST_ACCESS)) w_psel = w_onehot;
    else w_psel = '0;
    if (!bus.pp_rd_fifo_full && (w_done || ((r_state == ST_RESP) && !r_fifo_en))) w_fifo_en = 1'b1;
    else w_fifo_en = 1'b0;
    if (w_accept && !w_idx_ok)
      w_resp = build_resp(w_wr, 1'b1, 1'b0, w_idx, w_addr, 32'h0000_0000);
    else if (w_done && bus.pready)
      w_resp = build_resp(w_wr, bus.pslverr, 1'b0, w_idx, w_addr, w_wr ? 32'h0000_0000 : bus.prdata);
    else if (w_done)
      w_resp = build_resp(w_wr, 1'b0, 1'b1, w_idx, w_addr, 32'h0000_0000);
    else
      w_resp = r_resp;
  end

  // Output registers; bus address/data/direction only change on a valid accept.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_cmd       <= '0;
      r_resp      <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 12'h000;
      r_pwdata    <= 32'h0000_0000;
      r_cmd_ready <= 1'b0;
      r_fifo_en   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd       <= w_cmd;
      r_resp      <= w_resp;
      r_psel      <= w_psel;
      r_penable   <= (w_next == ST_ACCESS);
      r_cmd_ready <= (w_next == ST_IDLE);
      r_fifo_en   <= w_fifo_en;
      r_busy      <= (w_next != ST_IDLE);
      if (w_accept && w_idx_ok) begin
        r_paddr  <= w_addr;
        r_pwdata <= w_cmd[CMD_DATA_MSB:CMD_DATA_LSB];
        r_pwrite <= w_wr;
      end else begin
        r_paddr  <= r_paddr;
        r_pwdata <= r_pwdata;
        r_pwrite <= r_pwrite;
      end
    end
  end

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.psel            = r_psel;
  assign bus.penable         = r_penable;
  assign bus.pwrite          = r_pwrite;
  assign bus.paddr           = r_paddr;
  assign bus.pwdata          = r_pwdata;
  assign bus.pp_rd_fifo_en   = r_fifo_en;
  assign bus.pp_rd_fifo_data = r_resp;
  assign bus.busy            = r_busy;
endmodule
